// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-port memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} dmem_state_t;
  typedef enum logic {OP_READ, OP_WRITE} dmem_op_t;

  localparam int DMEM_WORD_W          = 16;
  localparam int DMEM_DEFAULT_LATENCY = 5;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, read-first, one-cycle registered read.
module dmem_array #(
  parameter int WORD_W    = 16,
  parameter int ADDR_BITS = 12
) (
  input  logic                 Clock,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);

  logic [WORD_W-1:0] r_mem [2**ADDR_BITS];

  // NOTE: the storage array has no reset; contents survive Reset, and a
  // reset port on a memory would prevent block-RAM inference.
  always_ff @(posedge Clock) begin
    if (we) r_mem[addr] <= wdata;
    rdata <= r_mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency memory responder for the processor's multi-cycle data port.
// Optional RdCount/WrCount ports are enabled by DATA_MEM_RESPONDER_STATS_EN.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int WORD_W    = DMEM_WORD_W,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = DMEM_DEFAULT_LATENCY
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [15:0]       DataAddr,
  input  logic [WORD_W-1:0] DataOut,
  input  logic              WriteData,
  input  logic              ReadData,
  output logic [WORD_W-1:0] DataIn,
`ifdef DATA_MEM_RESPONDER_STATS_EN
  output logic [15:0]       RdCount,
  output logic [15:0]       WrCount,
`endif
  output logic              DataDone
);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("data_mem_responder: LATENCY=%0d outside 1..15", LATENCY);
  end

  localparam logic [3:0] CNT_START = 4'(LATENCY - 1);

  dmem_state_t          r_state, w_next_state;
  dmem_op_t             r_op;
  logic [3:0]           r_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [WORD_W-1:0]    r_wdata;
  logic [WORD_W-1:0]    r_data_in;
  logic                 w_accept;
  logic                 w_finish;
  logic                 w_ram_we;
  logic [ADDR_BITS-1:0] w_ram_addr;
  logic [WORD_W-1:0]    w_ram_rdata;
  logic                 w_unused_addr;

  assign w_unused_addr = ^DataAddr[15:ADDR_BITS];

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: if (WriteData || ReadData) begin
        w_accept     = 1'b1;
        w_next_state = BUSY;
      end
      BUSY: if (r_cnt == 4'd0) begin
        w_finish     = 1'b1;
        w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The RAM address follows the live request while idle so that the
  // registered read is already valid on the final busy edge, even at LATENCY=1.
  assign w_ram_addr = (r_state == IDLE) ? DataAddr[ADDR_BITS-1:0] : r_addr;
  assign w_ram_we   = w_finish && (r_op == OP_WRITE) && !Reset;

  dmem_array #(
    .WORD_W   (WORD_W),
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .Clock(Clock),
    .we   (w_ram_we),
    .addr (w_ram_addr),
    .wdata(r_wdata),
    .rdata(w_ram_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_data_in <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_cnt <= CNT_START;
      end else if (r_state == BUSY && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_finish && r_op == OP_READ) r_data_in <= w_ram_rdata;
    end
  end

  // Transaction latches carry no reset; they are only consumed after an accept.
  always_ff @(posedge Clock) begin
    if (w_accept) begin
      r_addr  <= DataAddr[ADDR_BITS-1:0];
      r_wdata <= DataOut;
      r_op    <= WriteData ? OP_WRITE : OP_READ;
    end
  end

`ifdef DATA_MEM_RESPONDER_STATS_EN
  logic [15:0] r_rd_count, r_wr_count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else if (w_finish) begin
      if (r_op == OP_WRITE) r_wr_count <= r_wr_count + 16'd1;
      else                  r_rd_count <= r_rd_count + 16'd1;
    end
  end

  assign RdCount = r_rd_count;
  assign WrCount = r_wr_count;
`endif

  assign DataIn   = r_data_in;
  assign DataDone = (r_state != BUSY);

endmodule
